// File: rtl/edge_latency_sequencer.sv
// edge_latency_sequencer: drives NUM_EDGES level flips on stim_out and times
// the board's echo on resp_in, accumulating min/max/sum latency statistics.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   start      single-cycle pulse, starts a run from IDLE or DONE
//   resp_in    asynchronous echo from the board (2-flop synchronised)
//   stim_out   level driven to the board
//   busy       high while a run is in progress (ISSUE, WAIT_RESP, GAP)
//   done       high in DONE
//   err        0 = ok, 1 = timeout, 2 = start mismatch
//   edge_count number of echoes recorded this run
//   min_lat    smallest recorded latency (all-ones if none)
//   max_lat    largest recorded latency
//   sum_lat    sum of recorded latencies, modulo 2^SUM_W

module edge_latency_sequencer #(
    parameter int NUM_EDGES  = 1000,
    parameter int TIMEOUT    = 1000000,
    parameter int GAP_CYCLES = 100,
    parameter int SUM_W      = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             resp_in,
    output logic             stim_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic [31:0]      edge_count,
    output logic [31:0]      min_lat,
    output logic [31:0]      max_lat,
    output logic [SUM_W-1:0] sum_lat
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] E_OK       = 2'd0;
    localparam logic [1:0] E_TIMEOUT  = 2'd1;
    localparam logic [1:0] E_MISMATCH = 2'd2;

    // Terminal counts, pre-decremented so the compares need no adder.
    localparam logic [31:0] EDGE_LAST = 32'(NUM_EDGES - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
    // A zero gap still spends one cycle in GAP.
    localparam logic [31:0] GAP_LAST  =
        (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

    logic [2:0]  state;
    logic [2:0]  state_nx;
    logic        sync1;
    logic        resp_sync;
    logic [31:0] lat_cnt;
    logic [31:0] gap_cnt;
    logic [31:0] lat_now;

    logic        go;
    logic        mismatch;
    logic        rec_hit;
    logic        to_hit;
    logic        last_edge;
    logic        gap_end;

    assign busy = (state == S_ISSUE) ||
                  (state == S_WAIT)  ||
                  (state == S_GAP);
    assign done = (state == S_DONE);

    // Latency of the edge being recorded: the recording clock itself counts.
    assign lat_now   = lat_cnt + 32'd1;

    assign go        = start &&
                       ((state == S_IDLE) || (state == S_DONE));
    // The board must already echo the current level before a run begins.
    assign mismatch  = (resp_sync != stim_out);
    assign rec_hit   = (state == S_WAIT) && !mismatch;
    assign to_hit    = (state == S_WAIT) && mismatch &&
                       (lat_cnt == TO_LAST);
    assign last_edge = (edge_count == EDGE_LAST);
    assign gap_end   = (gap_cnt == GAP_LAST);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = mismatch ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (rec_hit) begin
                    state_nx = last_edge ? S_DONE : S_GAP;
                end else if (to_hit) begin
                    state_nx = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_nx = S_ISSUE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Two-flop synchroniser for the asynchronous echo.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            resp_sync <= 1'b0;
        end else begin
            sync1     <= resp_in;
            resp_sync <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // stim_out level carries over between runs; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stim_out <= 1'b0;
        end else if (state == S_ISSUE) begin
            stim_out <= ~stim_out;
        end
    end

    // Wait counter saturates at TIMEOUT-1 because the timeout leaves WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt <= 32'd0;
        end else if (state == S_ISSUE) begin
            lat_cnt <= 32'd0;
        end else if ((state == S_WAIT) && !rec_hit && !to_hit) begin
            lat_cnt <= lat_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= 32'd0;
        end else if (rec_hit) begin
            gap_cnt <= 32'd0;
        end else if ((state == S_GAP) && !gap_end) begin
            gap_cnt <= gap_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= E_OK;
        end else if (go) begin
            err <= mismatch ? E_MISMATCH : E_OK;
        end else if (to_hit) begin
            err <= E_TIMEOUT;
        end
    end

    // Statistics change only on start (clear) or on a recording edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_count <= 32'd0;
            min_lat    <= 32'hFFFF_FFFF;
            max_lat    <= 32'd0;
            sum_lat    <= '0;
        end else if (go) begin
            edge_count <= 32'd0;
            min_lat    <= 32'hFFFF_FFFF;
            max_lat    <= 32'd0;
            sum_lat    <= '0;
        end else if (rec_hit) begin
            edge_count <= edge_count + 32'd1;
            sum_lat    <= sum_lat + SUM_W'(lat_now);
            if (lat_now < min_lat) begin
                min_lat <= lat_now;
            end
            if (lat_now > max_lat) begin
                max_lat <= lat_now;
            end
        end
    end

endmodule

// File: tb/tb_edge_latency_sequencer.sv
// tb_edge_latency_sequencer: table-driven and randomized runs of
// edge_latency_sequencer against a delayed-echo board model.

module tb_edge_latency_sequencer;

    localparam int NE  = 4;
    localparam int TO  = 20;
    localparam int GAP = 2;
    localparam int SW  = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          resp_in;
    logic          stim_out;
    logic          busy;
    logic          done;
    logic [1:0]    err;
    logic [31:0]   edge_count;
    logic [31:0]   min_lat;
    logic [31:0]   max_lat;
    logic [SW-1:0] sum_lat;

    always #5 clk = ~clk;

    edge_latency_sequencer #(
        .NUM_EDGES  (NE),
        .TIMEOUT    (TO),
        .GAP_CYCLES (GAP),
        .SUM_W      (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .resp_in    (resp_in),
        .stim_out   (stim_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .edge_count (edge_count),
        .min_lat    (min_lat),
        .max_lat    (max_lat),
        .sum_lat    (sum_lat)
    );

    // Board model: echoes stim_out delayed by dly whole cycles,
    // or drives a forced level.
    int          dly       = 0;
    bit          force_en  = 1'b1;
    bit          force_val = 1'b0;
    logic [31:0] hist      = '0;

    always @(posedge clk) hist <= {hist[30:0], stim_out};

    always_comb begin
        resp_in = 1'b0;
        if (force_en) begin
            resp_in = force_val;
        end else if (dly == 0) begin
            resp_in = stim_out;
        end else begin
            resp_in = hist[5'(dly - 1)];
        end
    end

    typedef struct {
        int            d;
        int            inj;
        logic [1:0]    err;
        logic [31:0]   cnt;
        logic [31:0]   mn;
        logic [31:0]   mx;
        logic [SW-1:0] sum;
        int            cyc;
        bit            flip;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;
    bit model_stim = 1'b0;

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: constant echo delay d gives latency d+3 on every edge;
    // a latency beyond TO times out on the very first edge.
    function automatic vec_t model(input int d);
        vec_t v;
        int   l;
        int   g;
        l = d + 3;
        g = (GAP > 0) ? GAP : 1;
        v.d   = d;
        v.inj = 0;
        if (l <= TO) begin
            v.err  = 2'd0;
            v.cnt  = 32'(NE);
            v.mn   = 32'(l);
            v.mx   = 32'(l);
            v.sum  = SW'(NE * l);
            v.cyc  = NE * (1 + l) + (NE - 1) * g;
            v.flip = (NE % 2 == 1);
        end else begin
            v.err  = 2'd1;
            v.cnt  = 32'd0;
            v.mn   = 32'hFFFF_FFFF;
            v.mx   = 32'd0;
            v.sum  = '0;
            v.cyc  = 1 + TO;
            v.flip = 1'b1;
        end
        return v;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int cyc;
        force_en = 1'b0;
        dly = v.d;
        repeat (v.d + 6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 500) begin
            if (cyc + 1 == v.inj) start = 1'b1;
            tick();
            start = 1'b0;
            cyc++;
        end
        model_stim = model_stim ^ v.flip;
        chk({tag, "/cycles"}, 64'(cyc), 64'(v.cyc));
        chk({tag, "/done"},   done,       1);
        chk({tag, "/busy"},   busy,       0);
        chk({tag, "/err"},    err,        v.err);
        chk({tag, "/count"},  edge_count, v.cnt);
        chk({tag, "/min"},    min_lat,    v.mn);
        chk({tag, "/max"},    max_lat,    v.mx);
        chk({tag, "/sum"},    sum_lat,    v.sum);
        chk({tag, "/stim"},   stim_out,   model_stim);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "/stim"},  stim_out,   0);
        chk({tag, "/busy"},  busy,       0);
        chk({tag, "/done"},  done,       0);
        chk({tag, "/err"},   err,        0);
        chk({tag, "/count"}, edge_count, 0);
        chk({tag, "/min"},   min_lat,    32'hFFFF_FFFF);
        chk({tag, "/max"},   max_lat,    0);
        chk({tag, "/sum"},   sum_lat,    0);
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = '{0,  5,  2'd0, 32'd4, 32'd3,  32'd3,  6'd12, 22, 1'b0};
        tbl[1] = '{10, 0,  2'd0, 32'd4, 32'd13, 32'd13, 6'd52, 62, 1'b0};
        tbl[2] = '{1,  9,  2'd0, 32'd4, 32'd4,  32'd4,  6'd16, 26, 1'b0};
        tbl[3] = '{17, 30, 2'd0, 32'd4, 32'd20, 32'd20, 6'd16, 90, 1'b0};
        tbl[4] = '{18, 7,  2'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 6'd0, 21, 1'b1};

        // Reset wins over a simultaneous start.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk_reset_vals("reset");

        // Board already at the wrong level: immediate mismatch, no flip.
        force_en  = 1'b1;
        force_val = 1'b1;
        repeat (4) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mismatch/done",  done,       1);
        chk("mismatch/err",   err,        2);
        chk("mismatch/stim",  stim_out,   0);
        chk("mismatch/busy",  busy,       0);
        chk("mismatch/count", edge_count, 0);
        chk("mismatch/min",   min_lat,    32'hFFFF_FFFF);
        repeat (3) tick();
        chk("mismatch/noflip", stim_out, 0);

        for (int i = 0; i < 5; i++) begin
            run(tbl[i], $sformatf("tbl%0d", i));
        end

        // Reset in the second edge's wait; stim_out is 1 going in.
        begin
            int k;
            force_en = 1'b0;
            dly = 5;
            repeat (12) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
            k = 0;
            while (edge_count != 1 && k < 100) begin
                tick();
                k++;
            end
            chk("midrst/first_echo", 64'(k < 100), 1);
            repeat (5) tick();
            chk("midrst/busy_before", busy, 1);
            chk("midrst/stim_before", stim_out, 1);
            reset = 1'b1;
            tick();
            reset = 1'b0;
            chk_reset_vals("midrst");
            model_stim = 1'b0;
            repeat (3) tick();
            chk("midrst/idle", busy, 0);
            run(model(5), "postrst");
        end

        for (int i = 0; i < 25; i++) begin
            vec_t v;
            v = model(int'($urandom_range(0, 22)));
            if ($urandom_range(0, 1) == 1) begin
                v.inj = int'($urandom_range(1, v.cyc - 1));
            end
            run(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
